rr_byte_arbiter: RTL
====================

RR_BYTE_ARBITER -- requirements
Module: rr_byte_arbiter

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed (4 channels, 8-bit data).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req  input  4  per-channel request; bit i = channel i has a byte pending.
REQ-005 a, b, c, d  input  8 each  channel 0..3 data bytes, stable while the matching req bit is high.
REQ-006 select  output  2  granted channel index; drives the select of the downstream 8-bit 4:1 byte mux.
REQ-007 ack  output  4  one-hot, one-cycle grant strobe; the channel pops its byte on ack.
REQ-008 out_data  output  8  registered byte of the granted channel.
REQ-009 out_valid  output  1  out_data holds an untransferred byte.
REQ-010 out_ready  input  1  consumer accepts out_data when out_valid and out_ready are both high at a rising edge.
REQ-011 xfer_cnt  output  8  count of completed output transfers.

Function
REQ-012 Internal state SHALL be: FSM {IDLE, HOLD}; 2-bit priority pointer ptr; registers select, out_data, out_valid, xfer_cnt.
REQ-013 Winner SHALL be the first channel with req set, searched ptr, ptr+1, ptr+2, ptr+3 (mod 4).
REQ-014 A grant SHALL occur in a cycle iff |req and (state==IDLE or (out_valid and out_ready)).
REQ-015 In a grant cycle, ack SHALL be one-hot at the winner (combinational), and all other ack bits 0.
REQ-016 At the edge ending a grant cycle: out_data <= winner's byte (0:a, 1:b, 2:c, 3:d); select <= winner; out_valid <= 1; state <= HOLD; ptr <= winner+1, wrapping 3->0.
REQ-017 In IDLE with req==0, no register SHALL change; out_valid=0 and ack=0.
REQ-018 In HOLD with out_ready=0, out_data, select, ptr, and xfer_cnt SHALL hold; ack=0; req is ignored.
REQ-019 In HOLD with out_ready=1 and req==0, at the edge: out_valid <= 0; state <= IDLE; out_data and select hold their values.
REQ-020 In HOLD with out_ready=1 and |req, the block SHALL transfer and re-grant in the same cycle, so state stays HOLD and out_valid stays 1.
REQ-021 Sustained throughput SHALL therefore be one byte per cycle.
REQ-022 Grant latency SHALL be 1 cycle: out_valid is high in the cycle after ack.
REQ-023 xfer_cnt SHALL increment by 1 on each edge with out_valid and out_ready both high, wrapping 255->0.
REQ-024 A channel that holds req continuously SHALL be granted at least once every 4 grants (no starvation).

Reset
REQ-025 On an edge with rst=1, the block SHALL take the reset state regardless of all other inputs.
REQ-026 The reset state SHALL be: state=IDLE, ptr=0, select=2'b00, out_data=8'h00, out_valid=0, xfer_cnt=8'h00.
REQ-027 While rst=1, ack SHALL be 4'b0000.
REQ-028 A reset in HOLD SHALL discard the held byte and SHALL NOT count it as a transfer, even if out_ready=1 on that edge.
REQ-029 In the first cycle after rst deasserts, a grant SHALL be possible.

Verification
REQ-030 Reset: rst=1 for 2 cycles, req=4'b1111 -> ack=0000, out_valid=0, out_data=00, select=00, xfer_cnt=00.
REQ-031 Single request: a=95, b=43, c=BF, d=45 (hex), req=0100, out_ready=1.
  - Grant cycle: ack=0100.
  - Next cycle: out_valid=1, out_data=BF, select=10, ptr=3.
REQ-032 Round-robin: same data, req=1111, out_ready=1 held.
  - Grant order: 0,1,2,3,0.
  - out_data sequence: 95, 43, BF, 45, 95, one byte per cycle.
  - xfer_cnt advances by 1 per cycle.
REQ-033 Backpressure: in HOLD with out_data=43, out_ready=0 for 3 cycles.
  - During stall: out_data=43, select=01, ack=0000, xfer_cnt unchanged.
  - out_ready=1 -> xfer_cnt +1, next grant follows.
REQ-034 Pointer wrap: ptr=3, req=1001 -> channel 3 (out_data=45) granted first, then channel 0 (95); then ptr=1.
REQ-035 Reset mid-operation: rst=1 while out_valid=1 and out_ready=1 -> next cycle out_valid=0, xfer_cnt=00, ptr=0.

Source files
------------

// File: rtl/rr_byte_arbiter.sv
// Four-channel round-robin byte arbiter with a one-entry registered output slot.
// A new grant may be issued in the same cycle that the held byte drains, so throughput is one byte per cycle.
module rr_byte_arbiter (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req,
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic [7:0] c,
   input  logic [7:0] d,
   output logic [1:0] select,
   output logic [3:0] ack,
   output logic [7:0] out_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] xfer_cnt
);

   typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

   state_t     state_q;
   logic [1:0] ptr_q;
   logic [1:0] select_q;
   logic [7:0] out_data_q;
   logic       out_valid_q;
   logic [7:0] xfer_cnt_q;
   logic [7:0] xfer_cnt_d;

   logic [1:0] winner_s;
   logic       found_s;
   logic [1:0] probe_s;
   logic [7:0] win_byte_s;
   logic       xfer_s;
   logic       grant_s;

   // Rotating-priority search starting at the pointer
   always_comb begin
      winner_s = ptr_q;
      found_s  = 1'b0;
      probe_s  = ptr_q;
      for (int k = 0; k < 4; k++) begin
         probe_s = ptr_q + 2'(k);
         if (!found_s && req[probe_s]) begin
            winner_s = probe_s;
            found_s  = 1'b1;
         end else begin
            found_s  = found_s;
         end
      end
   end

   always_comb begin
      case (winner_s)
         2'd0:    win_byte_s = a;
         2'd1:    win_byte_s = b;
         2'd2:    win_byte_s = c;
         2'd3:    win_byte_s = d;
         default: win_byte_s = 8'h00;
      endcase
   end

   assign xfer_s     = out_valid_q & out_ready;
   assign grant_s    = ~rst & (|req) & ((state_q == IDLE) | xfer_s);
   assign xfer_cnt_d = xfer_cnt_q + 8'd1;

   always_comb begin
      ack = 4'b0000;
      if (grant_s) begin
         ack[winner_s] = 1'b1;
      end else begin
         ack = 4'b0000;
      end
   end

   // Reset discards a held byte without counting it
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         ptr_q       <= 2'd0;
         select_q    <= 2'b00;
         out_data_q  <= 8'h00;
         out_valid_q <= 1'b0;
         xfer_cnt_q  <= 8'h00;
      end else begin
         if (xfer_s) begin
            xfer_cnt_q <= xfer_cnt_d;
         end else begin
            xfer_cnt_q <= xfer_cnt_q;
         end
         case (state_q)
            IDLE: begin
               if (grant_s) begin
                  out_data_q  <= win_byte_s;
                  select_q    <= winner_s;
                  out_valid_q <= 1'b1;
                  ptr_q       <= winner_s + 2'd1;
                  state_q     <= HOLD;
               end else begin
                  state_q     <= IDLE;
               end
            end
            HOLD: begin
               if (grant_s) begin
                  out_data_q  <= win_byte_s;
                  select_q    <= winner_s;
                  out_valid_q <= 1'b1;
                  ptr_q       <= winner_s + 2'd1;
                  state_q     <= HOLD;
               end else if (xfer_s) begin
                  out_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end else begin
                  state_q     <= HOLD;
               end
            end
            default: begin
               state_q     <= IDLE;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign select    = select_q;
   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign xfer_cnt  = xfer_cnt_q;

endmodule
